// File: rtl/pipe_pkg.sv
// Shared ID/EX pipeline definitions: control-bundle width, decoder bit
// positions and the register-match helper used by the load-use detector.
package pipe_pkg;

   localparam int CTRL_W = 20;
   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;

   localparam int ALUOP_LSB    = 0;
   localparam int ALUOP_MSB    = 3;
   localparam int SHIFT_BIT    = 4;
   localparam int ZERO_EXT_BIT = 5;
   localparam int ALUSRC_BIT   = 6;
   localparam int REGDST_BIT   = 7;
   localparam int REGWRITE_BIT = 8;
   localparam int JUMP_BIT     = 9;
   localparam int BEQ_BIT      = 10;
   localparam int BNE_BIT      = 11;
   localparam int MEMREAD_BIT  = 12;
   localparam int MEMWRITE_BIT = 13;
   localparam int JAL_BIT      = 14;
   localparam int JR_BIT       = 15;
   localparam int SYSCALL_BIT  = 16;
   localparam int BLTZ_BIT     = 17;
   localparam int LH_BIT       = 18;
   localparam int RBVALID_BIT  = 19;

   // $0 is hard-wired, so a pending write to it can never create a hazard
   function automatic logic reg_match(input logic [REG_W-1:0] wnum,
                                      input logic [REG_W-1:0] rnum,
                                      input logic             rvalid);
      return rvalid && (wnum == rnum) && (wnum != 5'd0);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: raises stall when the load in EX targets a
// register the ID instruction reads; a taken branch/jump overrides it.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [CTRL_W-1:0] ex_ctrl,
   input  logic [REG_W-1:0]  ex_wnum,
   input  logic              id_ra_valid,
   input  logic [REG_W-1:0]  id_ra_num,
   input  logic              id_rb_valid,
   input  logic [REG_W-1:0]  id_rb_num,
   input  logic              flush,
   output logic              stall
);

   // Combinational load-use compare against both source operands
   always_comb begin
      stall = 1'b0;
      if (flush) begin
         stall = 1'b0;
      end else if (ex_ctrl[MEMREAD_BIT]) begin
         stall = reg_match(ex_wnum, id_ra_num, id_ra_valid) |
                 reg_match(ex_wnum, id_rb_num, id_rb_valid);
      end else begin
         stall = 1'b0;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, flush/stall
// bubble insertion and saturating-free (wrapping) bubble counters.
module id_ex_stage
   import pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [REG_W-1:0]  id_ra_num,
   input  logic [REG_W-1:0]  id_rb_num,
   input  logic              id_ra_valid,
   input  logic [DATA_W-1:0] id_ra_data,
   input  logic [DATA_W-1:0] id_rb_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_W-1:0]  id_shamt,
   input  logic [REG_W-1:0]  id_wnum,
   input  logic              flush,
   output logic              stall,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [DATA_W-1:0] ex_pc,
   output logic [REG_W-1:0]  ex_ra_num,
   output logic [REG_W-1:0]  ex_rb_num,
   output logic [DATA_W-1:0] ex_ra_data,
   output logic [DATA_W-1:0] ex_rb_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_W-1:0]  ex_shamt,
   output logic [REG_W-1:0]  ex_wnum,
   output logic [CNT_W-1:0]  loaduse_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic bubble_s;

   hazard_detect u_hazard_detect (
      .ex_ctrl     (ex_ctrl),
      .ex_wnum     (ex_wnum),
      .id_ra_valid (id_ra_valid),
      .id_ra_num   (id_ra_num),
      .id_rb_valid (id_ctrl[RBVALID_BIT]),
      .id_rb_num   (id_rb_num),
      .flush       (flush),
      .stall       (stall)
   );

   assign bubble_s = flush | stall;

   // EX register bank: bubbles zero only ctrl and wnum, data always loads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_ctrl     <= '0;
         ex_pc       <= 32'd0;
         ex_ra_num   <= 5'd0;
         ex_rb_num   <= 5'd0;
         ex_ra_data  <= 32'd0;
         ex_rb_data  <= 32'd0;
         ex_imm      <= 32'd0;
         ex_shamt    <= 5'd0;
         ex_wnum     <= 5'd0;
         loaduse_cnt <= 16'd0;
         flush_cnt   <= 16'd0;
      end else if (en) begin
         ex_pc      <= id_pc;
         ex_ra_num  <= id_ra_num;
         ex_rb_num  <= id_rb_num;
         ex_ra_data <= id_ra_data;
         ex_rb_data <= id_rb_data;
         ex_imm     <= id_imm;
         ex_shamt   <= id_shamt;
         if (bubble_s) begin
            ex_ctrl <= '0;
            ex_wnum <= 5'd0;
         end else begin
            ex_ctrl <= id_ctrl;
            ex_wnum <= id_wnum;
         end
         // stall is already masked by flush, so only one counter moves
         if (flush) begin
            flush_cnt <= flush_cnt + 16'd1;
         end else if (stall) begin
            loaduse_cnt <= loaduse_cnt + 16'd1;
         end else begin
            flush_cnt <= flush_cnt;
         end
      end else begin
         ex_ctrl <= ex_ctrl;
      end
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port EN  in  1  global advance enable; 0 freezes all state and counters.
REQ-004 SHALL have port ID_CTRL  in  20  packed decoder control bundle; layout per REQ-030.
REQ-005 SHALL have port ID_PC  in  32  PC of ID instruction.
REQ-006 SHALL have ports ID_RA_NUM, ID_RB_NUM  in  5 each  source register numbers.
REQ-007 SHALL have port ID_RA_VALID  in  1  instruction reads rA.
REQ-008 SHALL have ports ID_RA_DATA, ID_RB_DATA, ID_IMM  in  32 each  register-file operands and extended immediate.
REQ-009 SHALL have ports ID_SHAMT, ID_WNUM  in  5 each  shift amount and destination register number.
REQ-010 SHALL have port FLUSH  in  1  branch/jump taken, resolved in EX.
REQ-011 SHALL have port STALL  out  1  load-use hazard; holds PC and IF/ID.
REQ-012 SHALL have ports EX_CTRL, EX_PC, EX_RA_NUM, EX_RB_NUM, EX_RA_DATA, EX_RB_DATA, EX_IMM, EX_SHAMT, EX_WNUM  out  widths as ID_*  registered EX-stage copies.
REQ-013 SHALL have ports LOADUSE_CNT, FLUSH_CNT  out  16 each  bubble counters.

Function
REQ-014 STALL SHALL be combinational: EX_CTRL.MemRead=1 and EX_WNUM!=0 and ((ID_RA_VALID and EX_WNUM==ID_RA_NUM) or (ID_CTRL.rBValid and EX_WNUM==ID_RB_NUM)), forced 0 when FLUSH=1.
REQ-015 Register update priority per edge with EN=1: FLUSH > STALL > load.
REQ-016 Load SHALL copy every ID_* input into its EX_* register, latency 1 cycle.
REQ-017 FLUSH or STALL SHALL insert a bubble: EX_CTRL<=0 and EX_WNUM<=0; other EX_* data registers SHALL load normally (value don't-care).
REQ-018 Bubble EX_CTRL=0 SHALL never write register file or memory; no branch/jump/syscall.
REQ-019 EN=0 SHALL hold all EX_* registers and counters regardless of FLUSH/STALL; STALL output still evaluates.
REQ-020 LOADUSE_CNT SHALL increment by 1 on each edge with EN=1, STALL=1; wraps 0xFFFF->0.
REQ-021 FLUSH_CNT SHALL increment by 1 on each edge with EN=1, FLUSH=1; wraps 0xFFFF->0.
REQ-022 Simultaneous FLUSH and hazard SHALL count only FLUSH_CNT.
REQ-023 Load-use stall SHALL last exactly one cycle per load: the bubble clears EX MemRead, so STALL drops next cycle.
REQ-024 EX_WNUM=0 SHALL never raise STALL (register $0).

Reset
REQ-025 RST=1 SHALL immediately clear all EX_* registers, LOADUSE_CNT and FLUSH_CNT to 0, regardless of CLK and EN.
REQ-026 Reset mid-stall SHALL drop STALL to 0 immediately (EX_CTRL.MemRead cleared).
REQ-027 First edge after RST deasserts SHALL perform a normal REQ-015 update.

Structure
REQ-028 Shared package pipe_pkg SHALL hold CTRL_W=20 and all ID_CTRL bit-index constants.
REQ-029 Load-use compare SHALL be sub-module hazard_detect (combinational, outputs STALL).
REQ-030 ID_CTRL layout: [3:0] ALUOP, [4] Shift, [5] Zero_extend, [6] ALUSrc, [7] RegDst, [8] RegWrite, [9] Jump, [10] Beq, [11] Bne, [12] MemRead, [13] MemWrite, [14] Jal, [15] Jr, [16] Syscall, [17] Bltz, [18] Lh, [19] rBValid.

Verification
REQ-031 Reset: RST pulse mid-cycle with EX_CTRL=0x01005 -> EX_CTRL=0, counters 0, STALL=0 without clock edge.
REQ-032 Pass-through: ID_PC=0x00003004, ID_IMM=0xFFFFFFFC, EN=1 -> EX_PC=0x00003004, EX_IMM=0xFFFFFFFC one edge later.
REQ-033 Load-use: EX lw (MemRead) EX_WNUM=8, ID add rs=8 (ID_RA_VALID=1) -> STALL=1, next edge EX_CTRL=0, LOADUSE_CNT=1, STALL=0 following cycle.
REQ-034 Flush priority: FLUSH=1 with hazard as REQ-033 -> STALL=0, EX_CTRL=0, FLUSH_CNT=1, LOADUSE_CNT unchanged.
REQ-035 Zero/EN: EX lw to $0, ID reads $0 -> STALL=0; EN=0 with FLUSH=1 -> EX_* and FLUSH_CNT unchanged.
REQ-036 Wrap: preload 0xFFFF flushes then one more -> FLUSH_CNT=0x0000.
